// File: rtl/change_dispenser_if.sv
// Change request and coin hopper signals.
// master drives requests and acks; slave is the dispenser.
interface change_dispenser_if;
  logic        change_valid;
  logic [15:0] change_amount;
  logic        change_ready;
  logic        refill;
  logic        coin_eject;
  logic [1:0]  coin_type;
  logic        coin_ack;
  logic        done;
  logic        error;
  logic [15:0] short_amount;
  logic [3:0]  coin_empty;

  modport master (
    output change_valid, change_amount,
    output refill, coin_ack,
    input  change_ready, coin_eject, coin_type,
    input  done, error, short_amount, coin_empty
  );

  modport slave (
    input  change_valid, change_amount,
    input  refill, coin_ack,
    output change_ready, coin_eject, coin_type,
    output done, error, short_amount, coin_empty
  );
endinterface

// File: rtl/change_dispenser.sv
// Greedy coin hopper sequencer with inventory.
// Pays change one coin at a time, reports shortfall.
module change_dispenser #(
  parameter int DOLLAR_INIT  = 20,
  parameter int QUARTER_INIT = 40,
  parameter int DIME_INIT    = 40,
  parameter int NICKEL_INIT  = 40,
  parameter int CNT_W        = 8,
  parameter int ACK_TIMEOUT  = 16
) (
  input logic clk,
  input logic reset,
  change_dispenser_if.slave bus
);
  localparam int TW = $clog2(ACK_TIMEOUT) + 1;

  typedef enum logic [1:0] {
    IDLE, SELECT, EJECT, DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt [4];
  logic [15:0]      rem;
  logic [TW-1:0]    tcnt;
  logic [3:0]       ok;
  logic             any;
  logic [1:0]       pick;

  function automatic logic [15:0] coin_val(
    input logic [1:0] t
  );
    unique case (t)
      2'd0:    coin_val = 16'd100;
      2'd1:    coin_val = 16'd25;
      2'd2:    coin_val = 16'd10;
      default: coin_val = 16'd5;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] init_cnt(
    input int i
  );
    unique case (i)
      0:       init_cnt = CNT_W'(DOLLAR_INIT);
      1:       init_cnt = CNT_W'(QUARTER_INIT);
      2:       init_cnt = CNT_W'(DIME_INIT);
      default: init_cnt = CNT_W'(NICKEL_INIT);
    endcase
  endfunction

  // Denominations that fit the remainder and are in stock.
  always_comb begin
    ok = '0;
    for (int i = 0; i < 4; i++) begin
      ok[i] = (cnt[i] != '0) &&
              (coin_val(2'(i)) <= rem);
    end
    any = |ok;
    pick = 2'd0;
    priority case (1'b1)
      ok[0]:   pick = 2'd0;
      ok[1]:   pick = 2'd1;
      ok[2]:   pick = 2'd2;
      ok[3]:   pick = 2'd3;
      default: pick = 2'd0;
    endcase
  end

  assign bus.coin_empty = {
    cnt[3] == '0, cnt[2] == '0,
    cnt[1] == '0, cnt[0] == '0
  };

  // Sequencer, inventory and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      bus.change_ready <= 1'b1;
      bus.coin_eject   <= 1'b0;
      bus.coin_type    <= 2'd0;
      bus.done         <= 1'b0;
      bus.error        <= 1'b0;
      bus.short_amount <= '0;
      rem              <= '0;
      tcnt             <= '0;
      for (int i = 0; i < 4; i++)
        cnt[i] <= init_cnt(i);
    end else begin
      bus.done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.refill)
            for (int i = 0; i < 4; i++)
              cnt[i] <= init_cnt(i);
          if (bus.change_valid) begin
            rem              <= bus.change_amount;
            bus.error        <= 1'b0;
            bus.short_amount <= '0;
            bus.change_ready <= 1'b0;
            if (bus.change_amount == '0) begin
              state    <= DONE;
              bus.done <= 1'b1;
            end else begin
              state <= SELECT;
            end
          end
        end
        SELECT: begin
          if (any) begin
            bus.coin_type  <= pick;
            bus.coin_eject <= 1'b1;
            tcnt           <= '0;
            state          <= EJECT;
          end else begin
            bus.short_amount <= rem;
            bus.error        <= 1'b1;
            bus.done         <= 1'b1;
            state            <= DONE;
          end
        end
        EJECT: begin
          if (bus.coin_ack) begin
            rem <= rem - coin_val(bus.coin_type);
            cnt[bus.coin_type] <=
              cnt[bus.coin_type] - 1'b1;
            bus.coin_eject <= 1'b0;
            if (rem == coin_val(bus.coin_type)) begin
              state    <= DONE;
              bus.done <= 1'b1;
            end else begin
              state <= SELECT;
            end
          end else if (tcnt == TW'(ACK_TIMEOUT - 1)) begin
            bus.coin_eject   <= 1'b0;
            bus.error        <= 1'b1;
            bus.short_amount <= rem;
            bus.done         <= 1'b1;
            state            <= DONE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        DONE: begin
          state            <= IDLE;
          bus.change_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_change_dispenser.sv
// Directed self-checking bench for change_dispenser.
// Second instance runs with no quarters loaded.
module tb_change_dispenser;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  change_dispenser_if b1 ();
  change_dispenser_if b2 ();

  change_dispenser dut (
    .clk   (clk),
    .reset (reset),
    .bus   (b1)
  );

  change_dispenser #(.QUARTER_INIT(0)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (b2)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h want %0h",
             tag, got, exp);
    end
  endtask

  task automatic wait_eject(input string tag);
    int w = 0;
    while (b1.coin_eject !== 1'b1 && w < 8) begin
      step();
      w++;
    end
    chk(tag, 32'(b1.coin_eject), 32'd1);
  endtask

  task automatic pay(
    input logic [15:0] amt,
    input logic [31:0] seq,
    input int          n,
    input logic        exp_err,
    input logic [15:0] exp_short
  );
    int w;
    chk("ready_idle", 32'(b1.change_ready), 32'd1);
    b1.change_valid  = 1'b1;
    b1.change_amount = amt;
    step();
    b1.change_valid = 1'b0;
    for (int k = 0; k < n; k++) begin
      wait_eject("eject_up");
      chk("coin_type", 32'(b1.coin_type),
          32'(seq[2*k +: 2]));
      b1.coin_ack = 1'b1;
      step();
      b1.coin_ack = 1'b0;
      chk("eject_gap", 32'(b1.coin_eject), 32'd0);
    end
    w = 0;
    while (b1.done !== 1'b1 && w < 4) begin
      step();
      w++;
    end
    chk("done", 32'(b1.done), 32'd1);
    if (!exp_err)
      chk("done_lat", w, 0);
    chk("error", 32'(b1.error), 32'(exp_err));
    chk("short", 32'(b1.short_amount),
        32'(exp_short));
    step();
    chk("done_pulse", 32'(b1.done), 32'd0);
  endtask

  initial begin
    int c;
    logic seen;
    b1.change_valid = 0; b1.change_amount = 0;
    b1.refill = 0; b1.coin_ack = 0;
    b2.change_valid = 0; b2.change_amount = 0;
    b2.refill = 0; b2.coin_ack = 0;
    step();
    step();
    chk("rst_ready", 32'(b1.change_ready), 32'd1);
    chk("rst_eject", 32'(b1.coin_eject), 32'd0);
    chk("rst_type", 32'(b1.coin_type), 32'd0);
    chk("rst_done", 32'(b1.done), 32'd0);
    chk("rst_error", 32'(b1.error), 32'd0);
    chk("rst_short", 32'(b1.short_amount), 32'd0);
    chk("rst_empty", 32'(b1.coin_empty), 32'd0);
    chk("rst_empty2", 32'(b2.coin_empty), 32'h2);
    reset = 1'b0;
    step();

    // 50c: two quarters, check first-coin latency.
    b1.change_valid  = 1'b1;
    b1.change_amount = 16'd50;
    step();
    b1.change_valid = 1'b0;
    chk("sel_eject", 32'(b1.coin_eject), 32'd0);
    chk("sel_ready", 32'(b1.change_ready), 32'd0);
    step();
    chk("lat_eject", 32'(b1.coin_eject), 32'd1);
    chk("lat_type", 32'(b1.coin_type), 32'd1);
    b1.coin_ack = 1'b1;
    step();
    b1.coin_ack = 1'b0;
    chk("gap50", 32'(b1.coin_eject), 32'd0);
    step();
    chk("q2_eject", 32'(b1.coin_eject), 32'd1);
    chk("q2_type", 32'(b1.coin_type), 32'd1);
    b1.coin_ack = 1'b1;
    step();
    b1.coin_ack = 1'b0;
    chk("done50", 32'(b1.done), 32'd1);
    chk("err50", 32'(b1.error), 32'd0);
    chk("short50", 32'(b1.short_amount), 32'd0);
    chk("qcnt50", 32'(dut.cnt[1]), 32'd38);
    step();
    chk("ready50", 32'(b1.change_ready), 32'd1);

    // 185c: 100, 25, 25, 25, 10.
    pay(16'd185, 32'h254, 5, 1'b0, 16'd0);
    chk("dcnt185", 32'(dut.cnt[0]), 32'd19);
    chk("qcnt185", 32'(dut.cnt[1]), 32'd35);
    chk("mcnt185", 32'(dut.cnt[2]), 32'd39);

    // 7c: one nickel then a 2c shortfall.
    pay(16'd7, 32'h3, 1, 1'b1, 16'd2);
    chk("ncnt7", 32'(dut.cnt[3]), 32'd39);

    // Zero request completes right after accept.
    b1.change_valid  = 1'b1;
    b1.change_amount = 16'd0;
    step();
    b1.change_valid = 1'b0;
    chk("zero_done", 32'(b1.done), 32'd1);
    chk("zero_err", 32'(b1.error), 32'd0);
    step();

    // Refill restores every counter.
    b1.refill = 1'b1;
    step();
    b1.refill = 1'b0;
    chk("refill_d", 32'(dut.cnt[0]), 32'd20);
    chk("refill_q", 32'(dut.cnt[1]), 32'd40);
    chk("refill_n", 32'(dut.cnt[3]), 32'd40);

    // 100c with no ack: timeout after 16 cycles.
    b1.change_valid  = 1'b1;
    b1.change_amount = 16'd100;
    step();
    b1.change_valid = 1'b0;
    wait_eject("to_up");
    c = 0;
    while (b1.coin_eject === 1'b1 && c < 40) begin
      step();
      c++;
    end
    chk("to_len", c, 16);
    chk("to_done", 32'(b1.done), 32'd1);
    chk("to_err", 32'(b1.error), 32'd1);
    chk("to_short", 32'(b1.short_amount), 32'd100);
    chk("to_dcnt", 32'(dut.cnt[0]), 32'd20);
    step();

    // No-quarter instance: 40c as four dimes.
    b2.change_valid  = 1'b1;
    b2.change_amount = 16'd40;
    step();
    b2.change_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      c = 0;
      while (b2.coin_eject !== 1'b1 && c < 8) begin
        step();
        c++;
      end
      chk("nq_up", 32'(b2.coin_eject), 32'd1);
      chk("nq_type", 32'(b2.coin_type), 32'd2);
      chk("nq_empty", 32'(b2.coin_empty[1]), 32'd1);
      b2.coin_ack = 1'b1;
      step();
      b2.coin_ack = 1'b0;
    end
    chk("nq_done", 32'(b2.done), 32'd1);
    chk("nq_err", 32'(b2.error), 32'd0);
    step();

    // 200c interrupted by reset after first ack.
    b1.change_valid  = 1'b1;
    b1.change_amount = 16'd200;
    step();
    b1.change_valid = 1'b0;
    wait_eject("rs_up");
    chk("rs_type", 32'(b1.coin_type), 32'd0);
    b1.coin_ack = 1'b1;
    step();
    b1.coin_ack = 1'b0;
    chk("rs_dmid", 32'(dut.cnt[0]), 32'd19);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rs_eject", 32'(b1.coin_eject), 32'd0);
    chk("rs_ready", 32'(b1.change_ready), 32'd1);
    chk("rs_dcnt", 32'(dut.cnt[0]), 32'd20);
    seen = b1.done;
    for (int k = 0; k < 4; k++) begin
      step();
      seen = seen | b1.done | b1.coin_eject;
    end
    chk("rs_quiet", 32'(seen), 32'd0);
    pay(16'd25, 32'h1, 1, 1'b0, 16'd0);
    chk("rs_qcnt", 32'(dut.cnt[1]), 32'd39);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
